// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: a prescaler divides clk into count steps; start_stop, clear and load
// commands drive an IDLE/RUN/PAUSE/DONE machine with registered status outputs.
//   state | meaning
//   IDLE  | count cleared, waiting for start_stop
//   RUN   | prescaler advancing, count steps every TICKS cycles
//   PAUSE | prescaler and count frozen
//   DONE  | down-count reached zero, waiting for clear or load
module stopwatch_ctrl #(
  parameter int unsigned TICKS = 50_000_000,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_stop,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         down,
  output logic [W-1:0] count,
  output logic         running,
  output logic         tick,
  output logic         done
);

  localparam int unsigned PW = $clog2(TICKS);
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [W-1:0]  count_q, count_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic [W-1:0]  step_val;
  logic          ps_wrap;

  assign step_val = down ? (count_q - W'(1)) : (count_q + W'(1));
  assign ps_wrap  = (ps_q == PS_LAST);

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    count_d = count_q;
    tick_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      ps_d    = '0;
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
      ps_d    = '0;
      if (state_q == S_DONE) state_d = S_PAUSE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_stop) begin
            state_d = S_RUN;
            ps_d    = '0;
          end
        end
        S_RUN: begin
          // Pausing does not stall the prescaler on the edge it is requested
          if (start_stop && down && (count_q == '0)) begin
            state_d = S_DONE;
          end else begin
            if (ps_wrap) begin
              ps_d    = '0;
              count_d = step_val;
              tick_d  = 1'b1;
            end else begin
              ps_d = ps_q + PW'(1);
            end
            if (ps_wrap && down && (count_q == W'(1))) state_d = S_DONE;
            else if (start_stop)                       state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start_stop) state_d = S_RUN;
        end
        S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ps_q      <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule
